// File: rtl/arb_pkg.sv
// Shared definitions for memory_arbiter.
//   arb_state_e      : arbiter FSM state encoding
//   REQ_INST/REQ_DATA: requester identifiers used by the grant selector
//   STARVE_LIMIT_DEF : default consecutive-data-grant limit for the starve guard
package arb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GRANT_I = 3'd1,
        GRANT_D = 3'd2,
        DONE_I  = 3'd3,
        DONE_D  = 3'd4
    } arb_state_e;

    localparam logic REQ_INST = 1'b0;
    localparam logic REQ_DATA = 1'b1;

    localparam int STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/memory_arbiter_if.sv
// Bus bundle between the pipeline requesters, the arbiter and the unified memory.
//   INST_*  : fetch requester (read only)
//   DATA_*  : MEM-stage requester (read/write)
//   MEM_*   : single-port memory side
// Modports:
//   slave  : the arbiter's view (requests and memory responses in, results and strobes out)
//   master : the environment's view (pipeline + memory), the mirror of slave
interface memory_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              INST_READ;
    logic [ADDR_W-1:0] INST_ADDRESS;
    logic [DATA_W-1:0] INST_READDATA;
    logic              INST_BUSYWAIT;

    logic              DATA_READ;
    logic              DATA_WRITE;
    logic [ADDR_W-1:0] DATA_ADDRESS;
    logic [DATA_W-1:0] DATA_WRITEDATA;
    logic [DATA_W-1:0] DATA_READDATA;
    logic              DATA_BUSYWAIT;

    logic              MEM_READ;
    logic              MEM_WRITE;
    logic [ADDR_W-1:0] MEM_ADDRESS;
    logic [DATA_W-1:0] MEM_WRITEDATA;
    logic [DATA_W-1:0] MEM_READDATA;
    logic              MEM_BUSYWAIT;

    modport slave (
        input  INST_READ, INST_ADDRESS,
        output INST_READDATA, INST_BUSYWAIT,
        input  DATA_READ, DATA_WRITE, DATA_ADDRESS, DATA_WRITEDATA,
        output DATA_READDATA, DATA_BUSYWAIT,
        output MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
        input  MEM_READDATA, MEM_BUSYWAIT
    );

    modport master (
        output INST_READ, INST_ADDRESS,
        input  INST_READDATA, INST_BUSYWAIT,
        output DATA_READ, DATA_WRITE, DATA_ADDRESS, DATA_WRITEDATA,
        input  DATA_READDATA, DATA_BUSYWAIT,
        input  MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
        output MEM_READDATA, MEM_BUSYWAIT
    );

endinterface

// File: rtl/arb_grant_select.sv
// Picks which requester the arbiter serves next.
// Optional macro ARB_STARVE_GUARD_EN adds a counter of consecutive data grants
// taken while fetch is waiting; at STARVE_LIMIT, fetch is picked over data.
// Without the macro data always has strict priority and there is no state.
// Ports:
//   clk, rst   : clock / synchronous active-high reset (starve guard only)
//   arb_en     : arbiter is at an arbitration point this cycle (starve guard only)
//   inst_req   : fetch request pending
//   data_req   : load or store pending
//   pick_valid : some requester is pending
//   pick_req   : REQ_DATA or REQ_INST
module arb_grant_select
    import arb_pkg::*;
`ifdef ARB_STARVE_GUARD_EN
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
)
`endif
(
`ifdef ARB_STARVE_GUARD_EN
    input  logic clk,
    input  logic rst,
    input  logic arb_en,
`endif
    input  logic inst_req,
    input  logic data_req,
    output logic pick_valid,
    output logic pick_req
);

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;
    logic             starve_hit;

    always_comb begin
        starve_hit   = (starve_cnt_q == LIMIT);
        pick_valid   = inst_req | data_req;
        pick_req     = (data_req && !(inst_req && starve_hit)) ? REQ_DATA : REQ_INST;
        starve_cnt_d = starve_cnt_q;
        // The count only means "fetch has been waiting", so it clears as soon
        // as fetch stops asking, not just when fetch is granted.
        if (!inst_req) begin
            starve_cnt_d = '0;
        end else if (arb_en && pick_valid) begin
            if (pick_req == REQ_DATA) begin
                starve_cnt_d = starve_cnt_q + 1'b1;
            end else begin
                starve_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    always_comb begin
        pick_valid = inst_req | data_req;
        pick_req   = data_req ? REQ_DATA : REQ_INST;
    end
`endif

endmodule

// File: rtl/memory_arbiter.sv
// Shares one single-port multi-cycle memory between instruction fetch (read only)
// and the MEM stage (read/write). Data has priority; the optional macro
// ARB_STARVE_GUARD_EN bounds how long fetch can be held off.
// Ports:
//   CLK   : clock, rising edge
//   RESET : synchronous active-high reset
//   bus   : memory_arbiter_if.slave (requester and memory signals)
// All MEM_* outputs and both READDATA outputs are registered; the BUSYWAIT
// outputs are combinational: request active and not in the matching DONE state.
module memory_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
)(
    input  logic                CLK,
    input  logic                RESET,
    memory_arbiter_if.slave     bus
);

    arb_state_e        state_q, state_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
    logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
    logic              issued_q, issued_d;

    logic inst_req;
    logic data_req;
    logic pick_valid;
    logic pick_req;

    assign inst_req = bus.INST_READ;
    assign data_req = bus.DATA_READ | bus.DATA_WRITE;

`ifdef ARB_STARVE_GUARD_EN
    logic arb_en;
    assign arb_en = (state_q == IDLE) || (state_q == DONE_I) || (state_q == DONE_D);

    arb_grant_select #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_grant_select (
        .clk        (CLK),
        .rst        (RESET),
        .arb_en     (arb_en),
        .inst_req   (inst_req),
        .data_req   (data_req),
        .pick_valid (pick_valid),
        .pick_req   (pick_req)
    );
`else
    arb_grant_select u_grant_select (
        .inst_req   (inst_req),
        .data_req   (data_req),
        .pick_valid (pick_valid),
        .pick_req   (pick_req)
    );
`endif

    always_comb begin
        state_d      = state_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        issued_d     = issued_q;

        case (state_q)
            IDLE, DONE_I, DONE_D: begin
                if (pick_valid) begin
                    issued_d = 1'b0;
                    if (pick_req == REQ_DATA) begin
                        state_d     = GRANT_D;
                        mem_addr_d  = bus.DATA_ADDRESS;
                        mem_wdata_d = bus.DATA_WRITEDATA;
                        // A store wins when both strobes are raised together.
                        mem_write_d = bus.DATA_WRITE;
                        mem_read_d  = ~bus.DATA_WRITE;
                    end else begin
                        state_d     = GRANT_I;
                        mem_addr_d  = bus.INST_ADDRESS;
                        mem_read_d  = 1'b1;
                        mem_write_d = 1'b0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            GRANT_I, GRANT_D: begin
                // The memory cannot have reacted to the strobe in the cycle it
                // was raised, so MEM_BUSYWAIT is only trusted once issued.
                // A withdrawn request still runs to completion here.
                if (!issued_q) begin
                    issued_d = 1'b1;
                end else if (!bus.MEM_BUSYWAIT) begin
                    if (mem_read_q) begin
                        if (state_q == GRANT_I) begin
                            inst_rdata_d = bus.MEM_READDATA;
                        end else begin
                            data_rdata_d = bus.MEM_READDATA;
                        end
                    end
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = (state_q == GRANT_I) ? DONE_I : DONE_D;
                end
            end

            default: begin
                state_d     = IDLE;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= IDLE;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            issued_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            issued_q     <= issued_d;
        end
    end

    assign bus.MEM_READ      = mem_read_q;
    assign bus.MEM_WRITE     = mem_write_q;
    assign bus.MEM_ADDRESS   = mem_addr_q;
    assign bus.MEM_WRITEDATA = mem_wdata_q;
    assign bus.INST_READDATA = inst_rdata_q;
    assign bus.DATA_READDATA = data_rdata_q;
    assign bus.INST_BUSYWAIT = inst_req && (state_q != DONE_I);
    assign bus.DATA_BUSYWAIT = data_req && (state_q != DONE_D);

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed testbench for memory_arbiter with a small word memory model whose
// busy time after each strobe is set by mem_busy_cyc.
module tb_memory_arbiter;
    import arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    int          checks = 0;
    int          errors = 0;
    int          mem_busy_cyc = 0;
    int          busy_cnt = 0;
    logic [31:0] mem [0:15];

    memory_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    memory_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        case (i)
            0:       return 32'h0000_1234;
            1:       return 32'hCAFE_0001;
            2:       return 32'h0020_8033;
            3:       return 32'h0BAD_F00D;
            default: return 32'h0000_0100 + 32'(i);
        endcase
    endfunction

    // Memory: busy for the first mem_busy_cyc cycles of every strobe.
    assign bus.MEM_BUSYWAIT = (bus.MEM_READ | bus.MEM_WRITE) && (busy_cnt < mem_busy_cyc);
    assign bus.MEM_READDATA = mem[bus.MEM_ADDRESS[5:2]];

    always @(posedge clk) begin
        if (bus.MEM_READ | bus.MEM_WRITE) busy_cnt <= busy_cnt + 1;
        else                              busy_cnt <= 0;
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
        end else if (bus.MEM_WRITE && !bus.MEM_BUSYWAIT) begin
            mem[bus.MEM_ADDRESS[5:2]] <= bus.MEM_WRITEDATA;
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        bus.INST_READ = 1'b1;
        bus.INST_ADDRESS = 32'h4;
        repeat (3) @(negedge clk);
        checks++; if (bus.MEM_READ !== 1'b0) begin errors++; $display("FAIL reset_mem_read got %b exp 0", bus.MEM_READ); end
        checks++; if (bus.MEM_WRITE !== 1'b0) begin errors++; $display("FAIL reset_mem_write got %b exp 0", bus.MEM_WRITE); end
        checks++; if (bus.INST_BUSYWAIT !== 1'b1) begin errors++; $display("FAIL reset_inst_busywait got %b exp 1", bus.INST_BUSYWAIT); end
        checks++; if (bus.DATA_BUSYWAIT !== 1'b0) begin errors++; $display("FAIL reset_data_busywait got %b exp 0", bus.DATA_BUSYWAIT); end
        checks++; if (bus.INST_READDATA !== 32'h0) begin errors++; $display("FAIL reset_inst_rdata got %h exp 0", bus.INST_READDATA); end
        checks++; if (bus.DATA_READDATA !== 32'h0) begin errors++; $display("FAIL reset_data_rdata got %h exp 0", bus.DATA_READDATA); end
        checks++; if (bus.MEM_ADDRESS !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0", bus.MEM_ADDRESS); end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", dut.state_q, IDLE); end
        bus.INST_READ = 1'b0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_fetch();
        logic [4:0] exp_bw;
        exp_bw = 5'b01111;  // bit c = INST_BUSYWAIT expected in cycle c
        mem_busy_cyc = 2;
        bus.INST_READ = 1'b1;
        bus.INST_ADDRESS = 32'h8;
        #1;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            checks++; if (bus.INST_BUSYWAIT !== exp_bw[c]) begin errors++; $display("FAIL fetch_busywait cycle %0d got %b exp %b", c, bus.INST_BUSYWAIT, exp_bw[c]); end
            if (c == 1) begin
                checks++; if (bus.MEM_READ !== 1'b1 || bus.MEM_ADDRESS !== 32'h8) begin errors++; $display("FAIL fetch_issue got rd=%b addr=%h exp rd=1 addr=8", bus.MEM_READ, bus.MEM_ADDRESS); end
            end
        end
        checks++; if (bus.INST_READDATA !== 32'h0020_8033) begin errors++; $display("FAIL fetch_rdata got %h exp 00208033", bus.INST_READDATA); end
        checks++; if (bus.MEM_READ !== 1'b0) begin errors++; $display("FAIL fetch_strobe_drop got %b exp 0", bus.MEM_READ); end
        bus.INST_READ = 1'b0;
        @(negedge clk);
        checks++; if (dut.state_q !== IDLE || bus.INST_BUSYWAIT !== 1'b0) begin errors++; $display("FAIL fetch_after got state=%0d bw=%b exp state=0 bw=0", dut.state_q, bus.INST_BUSYWAIT); end
    endtask

    task automatic test_simultaneous();
        int n;
        mem_busy_cyc = 1;
        bus.INST_READ = 1'b1;
        bus.INST_ADDRESS = 32'h0;
        bus.DATA_WRITE = 1'b1;
        bus.DATA_ADDRESS = 32'h0;
        bus.DATA_WRITEDATA = 32'd30;
        @(negedge clk);
        checks++; if (bus.MEM_WRITE !== 1'b1 || bus.MEM_READ !== 1'b0 || bus.MEM_WRITEDATA !== 32'd30) begin errors++; $display("FAIL simul_first got wr=%b rd=%b wdata=%0d exp wr=1 rd=0 wdata=30", bus.MEM_WRITE, bus.MEM_READ, bus.MEM_WRITEDATA); end
        checks++; if (bus.INST_BUSYWAIT !== 1'b1) begin errors++; $display("FAIL simul_inst_stall got %b exp 1", bus.INST_BUSYWAIT); end
        n = 1;
        while (bus.DATA_BUSYWAIT === 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++; if (n != 3) begin errors++; $display("FAIL simul_data_done cycle got %0d exp 3", n); end
        bus.DATA_WRITE = 1'b0;
        @(negedge clk);
        checks++; if (bus.MEM_READ !== 1'b1 || bus.MEM_WRITE !== 1'b0 || bus.MEM_ADDRESS !== 32'h0 || dut.state_q !== GRANT_I) begin errors++; $display("FAIL simul_fetch_next got rd=%b wr=%b addr=%h state=%0d exp rd=1 wr=0 addr=0 state=1", bus.MEM_READ, bus.MEM_WRITE, bus.MEM_ADDRESS, dut.state_q); end
        n = 0;
        while (bus.INST_BUSYWAIT === 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++; if (n != 2) begin errors++; $display("FAIL simul_fetch_done cycles got %0d exp 2", n); end
        checks++; if (bus.INST_READDATA !== 32'd30) begin errors++; $display("FAIL simul_fetch_rdata got %0d exp 30", bus.INST_READDATA); end
        bus.INST_READ = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read_write_both();
        int n;
        mem_busy_cyc = 0;
        bus.DATA_READ = 1'b1;
        bus.DATA_ADDRESS = 32'h4;
        n = 0;
        #1;
        while (bus.DATA_BUSYWAIT === 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++; if (n != 3) begin errors++; $display("FAIL load_done cycle got %0d exp 3", n); end
        checks++; if (bus.DATA_READDATA !== 32'hCAFE_0001) begin errors++; $display("FAIL load_rdata got %h exp cafe0001", bus.DATA_READDATA); end
        bus.DATA_READ = 1'b0;
        @(negedge clk);
        bus.DATA_READ = 1'b1;
        bus.DATA_WRITE = 1'b1;
        bus.DATA_ADDRESS = 32'h10;
        bus.DATA_WRITEDATA = 32'h0000_A5A5;
        @(negedge clk);
        checks++; if (bus.MEM_WRITE !== 1'b1 || bus.MEM_READ !== 1'b0 || bus.MEM_ADDRESS !== 32'h10) begin errors++; $display("FAIL rw_both_strobe got wr=%b rd=%b addr=%h exp wr=1 rd=0 addr=10", bus.MEM_WRITE, bus.MEM_READ, bus.MEM_ADDRESS); end
        n = 1;
        while (bus.DATA_BUSYWAIT === 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++; if (n != 3) begin errors++; $display("FAIL rw_both_done cycle got %0d exp 3", n); end
        checks++; if (bus.DATA_READDATA !== 32'hCAFE_0001) begin errors++; $display("FAIL rw_both_rdata_kept got %h exp cafe0001", bus.DATA_READDATA); end
        bus.DATA_READ = 1'b0;
        bus.DATA_WRITE = 1'b0;
        @(negedge clk);
        checks++; if (mem[4] !== 32'h0000_A5A5) begin errors++; $display("FAIL rw_both_mem got %h exp 0000a5a5", mem[4]); end
    endtask

    task automatic test_flush();
        int n;
        mem_busy_cyc = 2;
        bus.INST_READ = 1'b1;
        bus.INST_ADDRESS = 32'hC;
        @(negedge clk);
        bus.INST_READ = 1'b0;
        #1;
        checks++; if (bus.INST_BUSYWAIT !== 1'b0 || bus.MEM_READ !== 1'b1) begin errors++; $display("FAIL flush_withdraw got bw=%b rd=%b exp bw=0 rd=1", bus.INST_BUSYWAIT, bus.MEM_READ); end
        repeat (3) @(negedge clk);
        checks++; if (dut.state_q !== DONE_I) begin errors++; $display("FAIL flush_done_state got %0d exp %0d", dut.state_q, DONE_I); end
        checks++; if (bus.INST_READDATA !== 32'h0BAD_F00D) begin errors++; $display("FAIL flush_rdata got %h exp 0badf00d", bus.INST_READDATA); end
        @(negedge clk);
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL flush_idle got %0d exp 0", dut.state_q); end
        mem_busy_cyc = 0;
        bus.INST_READ = 1'b1;
        bus.INST_ADDRESS = 32'h8;
        n = 0;
        #1;
        while (bus.INST_BUSYWAIT === 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++; if (n != 3 || bus.INST_READDATA !== 32'h0020_8033) begin errors++; $display("FAIL flush_next_fetch got cycle=%0d rdata=%h exp cycle=3 rdata=00208033", n, bus.INST_READDATA); end
        bus.INST_READ = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_starve();
        int         n;
        logic [7:0] grant_is_inst;
        logic [4:0] exp_inst;
        arb_state_e prev;
`ifdef ARB_STARVE_GUARD_EN
        exp_inst = 5'b10000;
`else
        exp_inst = 5'b00000;
`endif
        grant_is_inst = '0;
        mem_busy_cyc = 0;
        n = 0;
        prev = dut.state_q;
        bus.INST_READ = 1'b1;
        bus.INST_ADDRESS = 32'h4;
        bus.DATA_READ = 1'b1;
        bus.DATA_ADDRESS = 32'h8;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if ((dut.state_q == GRANT_D || dut.state_q == GRANT_I) && dut.state_q != prev && n < 8) begin
                grant_is_inst[n] = (dut.state_q == GRANT_I);
                n++;
            end
            prev = dut.state_q;
            if (bus.INST_READ && !bus.INST_BUSYWAIT) bus.INST_READ = 1'b0;
        end
        checks++; if (n < 5) begin errors++; $display("FAIL starve_grant_count got %0d exp >=5", n); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (grant_is_inst[i] !== exp_inst[i]) begin errors++; $display("FAIL starve_grant%0d got inst=%b exp inst=%b", i + 1, grant_is_inst[i], exp_inst[i]); end
        end
        bus.INST_READ = 1'b0;
        bus.DATA_READ = 1'b0;
        n = 0;
        while (dut.state_q !== IDLE && n < 10) begin @(negedge clk); n++; end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL starve_drain got state=%0d exp 0", dut.state_q); end
    endtask

    task automatic test_reset_mid_access();
        mem_busy_cyc = 3;
        bus.DATA_WRITE = 1'b1;
        bus.DATA_ADDRESS = 32'h20;
        bus.DATA_WRITEDATA = 32'h55;
        @(negedge clk);
        checks++; if (bus.MEM_WRITE !== 1'b1 || dut.state_q !== GRANT_D) begin errors++; $display("FAIL midrst_grant got wr=%b state=%0d exp wr=1 state=2", bus.MEM_WRITE, dut.state_q); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.MEM_WRITE !== 1'b0 || dut.state_q !== IDLE) begin errors++; $display("FAIL midrst_drop got wr=%b state=%0d exp wr=0 state=0", bus.MEM_WRITE, dut.state_q); end
        checks++; if (bus.DATA_BUSYWAIT !== 1'b1 || bus.INST_READDATA !== 32'h0 || bus.DATA_READDATA !== 32'h0) begin errors++; $display("FAIL midrst_outputs got bw=%b irdata=%h drdata=%h exp bw=1 irdata=0 drdata=0", bus.DATA_BUSYWAIT, bus.INST_READDATA, bus.DATA_READDATA); end
        bus.DATA_WRITE = 1'b0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        bus.INST_READ = 1'b0;
        bus.INST_ADDRESS = '0;
        bus.DATA_READ = 1'b0;
        bus.DATA_WRITE = 1'b0;
        bus.DATA_ADDRESS = '0;
        bus.DATA_WRITEDATA = '0;
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_read_write_both();
        test_flush();
        test_starve();
        test_reset_mid_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
